// File: rtl/microwave_timer_ctrl.sv
// Microwave cook timer: three-digit BCD M:SS countdown with keypad entry,
// a divided one-second tick, and the start/stop/door/done control FSM.
module microwave_timer_ctrl #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned DONE_CYCLES = 3
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state
);

    localparam int unsigned CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTING = 3'd1,
        ST_RUNNING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          mins_q, mins_d;
    logic [3:0]          tens_q, tens_d;
    logic [3:0]          ones_q, ones_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                mag_q, mag_d;
    logic                done_q, done_d;

    logic time_zero;
    logic time_one;
    logic tick;
    logic key_ok;

    // Status decodes of the current registered state.
    always_comb begin
        time_zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
        time_one  = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
        tick      = (cnt_q == CNT_LAST);
        // A seconds digit above 5 cannot shift into the tens-of-seconds slot.
        key_ok    = key_valid && (key_code <= 4'd9) && (ones_q <= 4'd5);
    end

    // Next-state, digit, divider and hold-counter logic (stop > door > start > key).
    always_comb begin
        state_d = state_q;
        mins_d  = mins_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                hold_d = '0;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    if (door_closed && time_zero) begin
                        mins_d  = 4'd0;
                        tens_d  = 4'd3;
                        ones_d  = 4'd0;
                        state_d = ST_RUNNING;
                    end
                end else if (key_ok) begin
                    mins_d  = tens_q;
                    tens_d  = ones_q;
                    ones_d  = key_code;
                    state_d = ST_SETTING;
                end
            end
            ST_SETTING: begin
                cnt_d  = '0;
                hold_d = '0;
                if (stop) begin
                    mins_d  = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    state_d = ST_IDLE;
                end else if (start) begin
                    if (door_closed && !time_zero) begin
                        state_d = ST_RUNNING;
                    end
                end else if (key_ok) begin
                    mins_d = tens_q;
                    tens_d = ones_q;
                    ones_d = key_code;
                end
            end
            ST_RUNNING: begin
                if (stop || !door_closed) begin
                    state_d = ST_PAUSED;
                end else begin
                    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                    if (tick) begin
                        if (time_zero || time_one) begin
                            mins_d  = 4'd0;
                            tens_d  = 4'd0;
                            ones_d  = 4'd0;
                            state_d = ST_DONE;
                        end else if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            if (tens_q != 4'd0) begin
                                tens_d = tens_q - 4'd1;
                            end else begin
                                tens_d = 4'd5;
                                mins_d = mins_q - 4'd1;
                            end
                        end
                    end
                end
            end
            ST_PAUSED: begin
                if (stop) begin
                    mins_d  = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (start && door_closed && !time_zero) begin
                    cnt_d   = '0;
                    state_d = ST_RUNNING;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    cnt_d   = '0;
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                    if (tick) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d  = '0;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                hold_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        mag_d  = (state_d == ST_RUNNING);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            mins_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            cnt_q   <= '0;
            hold_q  <= '0;
            mag_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mins_q  <= mins_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            mag_q   <= mag_d;
            done_q  <= done_d;
        end
    end

    assign mins     = mins_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign mag_on   = mag_q;
    assign done     = done_q;
    assign state    = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench for microwave_timer_ctrl with TICK_DIV=4, DONE_CYCLES=3.
module tb_microwave_timer_ctrl;

    logic       clock;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       mag_on;
    logic       done;
    logic [2:0] state;

    microwave_timer_ctrl #(
        .TICK_DIV    (4),
        .DONE_CYCLES (3)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .mins        (mins),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .mag_on      (mag_on),
        .done        (done),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic [2:0] st;
        logic       mag;
        logic       dn;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Queue an expected output snapshot for the monitor.
    task automatic expect_out(input string name, input int m, input int t, input int o,
                              input int st, input int mag, input int dn);
        exp_t e;
        e.name = name;
        e.m    = 4'(m);
        e.t    = 4'(t);
        e.o    = 4'(o);
        e.st   = 3'(st);
        e.mag  = 1'(mag);
        e.dn   = 1'(dn);
        exp_q.push_back(e);
    endtask

    // Monitor: compare outputs against queued expectations away from the active edge.
    always @(negedge clock) begin
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if ({mins, sec_tens, sec_ones, state, mag_on, done} ===
                {e.m, e.t, e.o, e.st, e.mag, e.dn}) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %0d:%0d%0d st=%0d mag=%0d done=%0d, want %0d:%0d%0d st=%0d mag=%0d done=%0d",
                         e.name, mins, sec_tens, sec_ones, state, mag_on, done,
                         e.m, e.t, e.o, e.st, e.mag, e.dn);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press(input int k);
        key_valid = 1'b1;
        key_code  = 4'(k);
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    initial begin
        clear       = 1'b0;
        key_valid   = 1'b0;
        key_code    = 4'd0;
        start       = 1'b0;
        stop        = 1'b0;
        door_closed = 1'b1;
        step(3);
        clear = 1'b1;
        expect_out("reset", 0, 0, 0, 0, 0, 0);

        // Clear asserted while running at 1:23
        press(1); press(2); press(3);
        expect_out("enter_123", 1, 2, 3, 1, 0, 0);
        do_start();
        expect_out("run_123", 1, 2, 3, 2, 1, 0);
        step(2);
        clear = 1'b0;
        expect_out("async_clear", 0, 0, 0, 0, 0, 0);
        step(2);
        clear = 1'b1;
        step(10);
        expect_out("idle_after_clear", 0, 0, 0, 0, 0, 0);

        // Key entry, illegal-shift drop, invalid code
        press(1);
        expect_out("key_1", 0, 0, 1, 1, 0, 0);
        press(3);
        expect_out("key_3", 0, 1, 3, 1, 0, 0);
        press(0);
        expect_out("key_0", 1, 3, 0, 1, 0, 0);
        press(7);
        expect_out("key_7", 3, 0, 7, 1, 0, 0);
        press(9);
        expect_out("key_9_dropped", 3, 0, 7, 1, 0, 0);
        press(12);
        expect_out("key_12_ignored", 3, 0, 7, 1, 0, 0);
        do_stop();
        expect_out("setting_stop", 0, 0, 0, 0, 0, 0);

        // Countdown 1:00 -> 0:59 -> 0:58 with mins borrow
        press(1); press(0); press(0);
        expect_out("enter_100", 1, 0, 0, 1, 0, 0);
        do_start();
        expect_out("start_100", 1, 0, 0, 2, 1, 0);
        step(3);
        expect_out("pre_tick", 1, 0, 0, 2, 1, 0);
        step(1);
        expect_out("tick_059", 0, 5, 9, 2, 1, 0);
        step(4);
        expect_out("tick_058", 0, 5, 8, 2, 1, 0);
        do_stop();
        expect_out("run_stop_pause", 0, 5, 8, 3, 0, 0);
        do_stop();
        expect_out("pause_stop_idle", 0, 0, 0, 0, 0, 0);

        // Run to zero, DONE hold of three ticks
        press(2);
        expect_out("enter_002", 0, 0, 2, 1, 0, 0);
        do_start();
        step(4);
        expect_out("tick_001", 0, 0, 1, 2, 1, 0);
        step(4);
        expect_out("reach_done", 0, 0, 0, 4, 0, 1);
        step(11);
        expect_out("done_held", 0, 0, 0, 4, 0, 1);
        step(1);
        expect_out("done_to_idle", 0, 0, 0, 0, 0, 0);

        // Door open pauses, start blocked with door open, stop beats start
        press(4); press(5);
        expect_out("enter_045", 0, 4, 5, 1, 0, 0);
        do_start();
        step(2);
        door_closed = 1'b0;
        step(1);
        expect_out("door_pause", 0, 4, 5, 3, 0, 0);
        do_start();
        expect_out("start_door_open", 0, 4, 5, 3, 0, 0);
        step(5);
        expect_out("paused_frozen", 0, 4, 5, 3, 0, 0);
        door_closed = 1'b1;
        do_start();
        expect_out("resume", 0, 4, 5, 2, 1, 0);
        step(4);
        expect_out("tick_044", 0, 4, 4, 2, 1, 0);
        stop  = 1'b1;
        start = 1'b1;
        step(1);
        stop  = 1'b0;
        start = 1'b0;
        expect_out("stop_beats_start", 0, 4, 4, 3, 0, 0);
        do_stop();
        expect_out("pause_clear", 0, 0, 0, 0, 0, 0);

        // Quick start blocked by open door, then quick start proper
        door_closed = 1'b0;
        do_start();
        expect_out("quick_door_open", 0, 0, 0, 0, 0, 0);
        door_closed = 1'b1;
        do_start();
        expect_out("quick_start", 0, 3, 0, 2, 1, 0);
        press(5);
        expect_out("key_in_running", 0, 3, 0, 2, 1, 0);
        do_stop();
        expect_out("quick_pause", 0, 3, 0, 3, 0, 0);
        do_stop();
        expect_out("quick_idle", 0, 0, 0, 0, 0, 0);

        step(2);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
